ysyx_23060077_riscv_ex_muldiv: RTL and testbench
================================================

Name: ysyx_23060077_riscv_ex_muldiv

Overview:
Iterative RV32M multiply/divide unit for the EX stage. Handles all eight M-extension ops with a shared shift/add-subtract datapath, one bit per cycle. A valid/ready handshake on both sides lets the pipeline controller stall EX while an op runs. Sits beside the single-cycle ALU and is selected when opcode is OP and funct7 is 0000001.

Parameters:
DATA_WIDTH, 32, operand/result width
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
funct3  input  3  inst[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_WIDTH  rs1 value
op_b  input  DATA_WIDTH  rs2 value
flush  input  1  kill the in-flight op (branch mispredict or trap)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  DATA_WIDTH  op result
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0, all internal registers 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&!flush, latch funct3, op_a and op_b, then go to PREP.
  - PREP (1 cycle):
    - Compute operand signs per op. MULH/DIV/REM treat both operands as signed. MULHSU treats only op_a as signed. MUL, MULHU, DIVU and REMU treat both as unsigned.
    - Take absolute values and record result sign.
    - For MUL*: result sign = sign_a^sign_b.
    - For DIV: quotient sign = sign_a^sign_b. For REM: remainder sign = sign_a.
    - Load counter=DATA_WIDTH, then go to CALC.
  - CALC (DATA_WIDTH cycles):
    - Multiply: shift-add into a 2*DATA_WIDTH product register.
    - Divide: restoring division, one quotient bit per cycle.
    - Counter decrements each cycle. Go to FIX when counter reaches 1.
  - FIX (1 cycle): apply sign correction (two's complement if negative) and select the output.
    - MUL returns low word. MULH, MULHSU and MULHU return high word.
    - DIV and DIVU return the quotient. REM and REMU return the remainder.
    - Register result, set out_valid=1, go to DONE.
  - DONE: hold result and out_valid stable. When out_valid&&out_ready, clear out_valid and go to IDLE.
- Latency: a request accepted at edge T gives out_valid=1 from edge T+DATA_WIDTH+2 (34 for default). There is no back-to-back issue: in_ready rises one cycle after the result handshake.
- Division special cases (RISC-V defined, no trap):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU remainder = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
  - These results come from the datapath or explicit override in FIX. Latency is unchanged unless the optional feature is enabled.
- Flush:
  - Any state returns to IDLE at the next edge.
  - out_valid goes to 0 and result holds its last value.
  - flush in IDLE together with in_valid: the request is not accepted.
  - flush in DONE together with out_ready: the flush wins and the result is discarded.
- Reset mid-operation: immediate return to reset values, no output produced.
- Input stability: operands are sampled only at the accept edge; later changes to op_a/op_b/funct3 are ignored.

Optional Feature:
Macro RISCV_MULDIV_FAST_EN.
- Defined: PREP detects divisor==0, signed-division overflow, or a multiply with either operand 0. It skips CALC and goes to FIX directly. out_valid rises at T+3.
- Undefined: every op takes the full DATA_WIDTH+2 latency; results are identical in both builds.

Test Plan:
- Reset asserted mid-CALC -> in_ready=1, out_valid=0, busy=0 immediately; next request completes normally.
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB at T+34; MULHU same operands -> 0x00000006; MULH -> 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU op_a=100, op_b=7 -> 14; REMU -> 2.
- DIV op_b=0, op_a=5 -> 0xFFFFFFFF; REM -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With RISCV_MULDIV_FAST_EN, out_valid at T+3.
- out_ready held 0 for 10 cycles after out_valid -> result stable, in_ready=0; out_ready=1 -> handshake, in_ready=1 next cycle.
- flush at CALC cycle 15 -> IDLE next edge, out_valid never asserted; flush with in_valid in IDLE -> no accept, busy stays 0.

Source files
------------

// File: rtl/ysyx_23060077_riscv_ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One bit per cycle over a shared shift/add-subtract datapath: shift-add
// multiply into {acc_q, lo_q}, restoring divide with the remainder in acc_q
// and the quotient shifting into lo_q. Operands are made positive in PREP
// and the sign is restored in FIX.
// Optional build macro RISCV_MULDIV_FAST_EN: trivial cases (divide by zero,
// signed divide overflow, multiply by zero) bypass the iterations.
module ysyx_23060077_riscv_ex_muldiv #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  busy
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

   state_e               state_q;
   logic [2:0]           funct3_q;
   logic [W-1:0]         a_q;        // raw op_a until PREP, then |op_a| (multiplicand)
   logic [W-1:0]         b_q;        // raw op_b until PREP, then |op_b| (divisor)
   logic [W-1:0]         acc_q;      // product high word / partial remainder
   logic [W-1:0]         lo_q;       // multiplier-then-product low word / dividend-then-quotient
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 neg_q;      // result must be negated in FIX
   logic                 bzero_q;    // divisor was zero
   logic [W-1:0]         result_q;
   logic                 out_valid_q;
`ifdef RISCV_MULDIV_FAST_EN
   logic                 skip_q;     // trivial case: leave datapath untouched
   logic                 skip_d;
`endif

   logic         is_div;
   logic         signed_a, signed_b, sgn_a, sgn_b, neg_d;
   logic [W-1:0] abs_a, abs_b;
   logic [W:0]   mul_sum;
   logic [W:0]   div_shift;
   logic         div_ge;
   logic [W-1:0] acc_step_d, lo_step_d;
   logic [W-1:0] mul_lo, mul_hi, quo, rem, fix_d;

   // Sign decode, one datapath step, and FIX-stage output selection.
   // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
   always_comb begin
      is_div     = funct3_q[2];
      signed_a   = '0;
      signed_b   = '0;
      acc_step_d = acc_q;
      lo_step_d  = lo_q;
      fix_d      = result_q;
`ifdef RISCV_MULDIV_FAST_EN
      skip_d     = '0;
`endif

      // DIV/REM signed on both; MULH both; MULHSU only op_a.
      if (is_div) begin
         signed_a = ~funct3_q[0];
         signed_b = ~funct3_q[0];
      end else begin
         signed_a = (funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10);
         signed_b = (funct3_q[1:0] == 2'b01);
      end
      sgn_a = signed_a & a_q[W-1];
      sgn_b = signed_b & b_q[W-1];
      abs_a = sgn_a ? -a_q : a_q;
      abs_b = sgn_b ? -b_q : b_q;
      // Remainder takes the dividend's sign; everything else takes the xor.
      neg_d = (is_div && funct3_q[1]) ? sgn_a : (sgn_a ^ sgn_b);

`ifdef RISCV_MULDIV_FAST_EN
      if (is_div)
         skip_d = (b_q == '0) ||
                  (!funct3_q[0] && (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1));
      else
         skip_d = (a_q == '0) || (b_q == '0);
`endif

      // Multiply: add multiplicand on lo bit, then shift {acc, lo} right.
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      // Divide: shift next dividend bit into the remainder, subtract if it fits.
      div_shift = {acc_q, lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      if (is_div) begin
         acc_step_d = div_ge ? (div_shift[W-1:0] - b_q) : div_shift[W-1:0];
         lo_step_d  = {lo_q[W-2:0], div_ge};
      end else begin
         acc_step_d = mul_sum[W:1];
         lo_step_d  = {mul_sum[0], lo_q[W-1:1]};
      end

      // Two's complement of the 64-bit product split across both words.
      mul_lo = neg_q ? -lo_q : lo_q;
      mul_hi = neg_q ? (~acc_q + W'(lo_q == '0)) : acc_q;
      quo    = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
      rem    = neg_q ? -acc_q : acc_q;
      if (is_div)
         fix_d = funct3_q[1] ? rem : quo;
      else
         fix_d = (funct3_q[1:0] == 2'b00) ? mul_lo : mul_hi;
   end

   // Control FSM and datapath registers; flush returns to IDLE and keeps result.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         funct3_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         bzero_q     <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
`ifdef RISCV_MULDIV_FAST_EN
         skip_q      <= 1'b0;
`endif
      end else if (flush) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  funct3_q <= funct3;
                  a_q      <= op_a;
                  b_q      <= op_b;
                  state_q  <= S_PREP;
               end
            end
            S_PREP: begin
               a_q     <= abs_a;
               b_q     <= abs_b;
               neg_q   <= neg_d;
               bzero_q <= (b_q == '0);
               acc_q   <= '0;
               lo_q    <= is_div ? abs_a : abs_b;
               cnt_q   <= CNT_WIDTH'(W);
               state_q <= S_CALC;
`ifdef RISCV_MULDIV_FAST_EN
               skip_q  <= skip_d;
               if (skip_d) begin
                  // One idle CALC cycle; registers preloaded with the final answer.
                  cnt_q <= CNT_WIDTH'(1);
                  if (is_div)
                     acc_q <= (b_q == '0) ? abs_a : '0;
                  else
                     lo_q  <= '0;
               end
`endif
            end
            S_CALC: begin
`ifdef RISCV_MULDIV_FAST_EN
               if (!skip_q) begin
                  acc_q <= acc_step_d;
                  lo_q  <= lo_step_d;
               end
`else
               acc_q <= acc_step_d;
               lo_q  <= lo_step_d;
`endif
               cnt_q <= cnt_q - CNT_WIDTH'(1);
               if (cnt_q == CNT_WIDTH'(1))
                  state_q <= S_FIX;
            end
            S_FIX: begin
               result_q    <= fix_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_ex_muldiv.sv
// Self-checking bench for ysyx_23060077_riscv_ex_muldiv: a 64-bit arithmetic
// reference model feeds an expectation queue that a negedge monitor compares
// against result/out_valid latency every cycle out_valid is high.
module tb_ysyx_23060077_riscv_ex_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   funct3 = '0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         busy;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   logic [W-1:0] last_res = '0;

   typedef struct {
      logic [W-1:0] res;
      int           t;
      int           lat;
      bit           seen;
   } exp_t;
   exp_t exp_q[$];

   ysyx_23060077_riscv_ex_muldiv #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .op_a      (op_a),
      .op_b      (op_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // RISC-V M-extension semantics with plain wide arithmetic.
   function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [63:0] ae, be, p;
      logic signed [W-1:0] sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b011: begin
            ae = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[W-1]}}, a} : {32'b0, a};
            be = (f3 == 3'b001) ? {{32{b[W-1]}}, b} : {32'b0, b};
            p  = ae * be;
            return (f3 == 3'b000) ? p[31:0] : p[63:32];
         end
         3'b100: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         3'b101: return (b == 0) ? '1 : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef RISCV_MULDIV_FAST_EN
      if (f3[2] ? (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                : (a == 0 || b == 0))
         return 3;
`endif
      return W + 2;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Compare process: every cycle the output is valid, check value and first-valid latency.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 1'b0);
         end else begin
            if (!exp_q[0].seen) begin
               check("latency", cyc - exp_q[0].t, exp_q[0].lat);
               exp_q[0].seen = 1'b1;
            end
            check("result", result, exp_q[0].res);
            if (out_ready && !flush) void'(exp_q.pop_front());
         end
      end
   end

   // Called #1 after a rising edge with the unit idle.
   task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      check("in_ready_before_issue", in_ready, 1'b1);
      in_valid = 1'b1;
      funct3   = f3;
      op_a     = a;
      op_b     = b;
      @(posedge clk); #1;
      e.res  = model(f3, a, b);
      e.t    = cyc;
      e.lat  = exp_lat(f3, a, b);
      e.seen = 1'b0;
      exp_q.push_back(e);
      last_res = e.res;
      in_valid = 1'b0;
      funct3   = 3'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            return;
         end
      end
      check("out_valid_timeout", out_valid, 1'b1);
   endtask

   task automatic finish_op(input int hold);
      bit ok;
      wait_valid(ok);
      if (!ok) begin
         exp_q.delete();
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_hs_out_valid", out_valid, 1'b0);
      check("post_hs_in_ready", in_ready, 1'b1);
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
      start_op(f3, a, b);
      finish_op(hold);
   endtask

   initial begin
      int seen;
      bit ok;
      logic [W-1:0] held;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_result", result, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Pin the model with hand-computed values
      check("pin_mul",    model(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      check("pin_mulhu",  model(3'b011, 32'd7, 32'hFFFF_FFFD), 32'h0000_0006);
      check("pin_mulh",   model(3'b001, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFFF);
      check("pin_mulhsu", model(3'b010, 32'd2, 32'hFFFF_FFFF), 32'h0000_0001);
      check("pin_div",    model(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("pin_rem",    model(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("pin_divu",   model(3'b101, 32'd100, 32'd7), 32'd14);
      check("pin_remu",   model(3'b111, 32'd100, 32'd7), 32'd2);
      check("pin_div0",   model(3'b100, 32'd5, 32'd0), 32'hFFFF_FFFF);
      check("pin_rem0",   model(3'b110, 32'd5, 32'd0), 32'd5);
      check("pin_divov",  model(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      check("pin_remov",  model(3'b110, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

      // Directed operations through the DUT
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'b011, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'b001, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 0);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'b101, 32'd100, 32'd7, 0);
      run_op(3'b111, 32'd100, 32'd7, 0);
      run_op(3'b100, 32'd5, 32'd0, 0);
      run_op(3'b110, 32'd5, 32'd0, 0);
      run_op(3'b101, 32'd5, 32'd0, 0);
      run_op(3'b111, 32'd5, 32'd0, 0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);

      // Back-pressure: result held for 10 cycles
      run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 10);

      // Reset in the middle of CALC
      start_op(3'b100, $urandom, $urandom);
      repeat (17) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_result", result, '0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(3'b101, 32'd1000, 32'd33, 0);

      // Flush during CALC cycle 15
      start_op(3'b000, $urandom, $urandom);
      @(posedge clk);
      repeat (15) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      last_res = model(3'b101, 32'd1000, 32'd33);
      check("flush_busy", busy, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush_no_output", seen, 0);
      check("flush_result_hold", result, last_res);
      @(posedge clk); #1;

      // Flush together with in_valid in IDLE
      in_valid = 1'b1;
      flush    = 1'b1;
      funct3   = 3'b000;
      op_a     = 32'd3;
      op_b     = 32'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      check("idle_flush_busy", busy, 1'b0);
      check("idle_flush_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      check("idle_flush_busy_later", busy, 1'b0);

      // Flush together with out_ready in DONE: result discarded, value held
      held = model(3'b110, 32'd77, 32'd10);
      start_op(3'b110, 32'd77, 32'd10);
      wait_valid(ok);
      @(posedge clk); #1;
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      flush     = 1'b0;
      exp_q.delete();
      check("done_flush_out_valid", out_valid, 1'b0);
      check("done_flush_in_ready", in_ready, 1'b1);
      check("done_flush_result", result, held);

      // Randomised operations
      for (int i = 0; i < 60; i++)
         run_op(3'($urandom), pick(), pick(), $urandom_range(0, 3));

      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
